bcd_to_binary_seq: RTL and testbench



---
 rtl/bcd_to_binary_seq.sv | 133 +++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Optional invalid-digit detection is built when BCD_DIGIT_CHECK_EN is defined.
module bcd_to_binary_seq #(
   parameter int DIGITS    = 2,
   parameter int BIN_WIDTH = 7
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_Start,
   input  logic [4*DIGITS-1:0]    i_BCD,
   output logic                   o_Busy,
   output logic                   o_Done,
   output logic [BIN_WIDTH-1:0]   o_Binary,
   output logic                   o_Error
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                    state;
   state_t                    state_next;
   logic [BCD_W-1:0]          bcd_sr;
   logic [BIN_WIDTH-1:0]      bin_sr;
   logic [CNT_W-1:0]          cnt;
   logic [BCD_W+BIN_WIDTH-1:0] shifted;
   logic [BCD_W-1:0]          bcd_next;
   logic [BIN_WIDTH-1:0]      bin_next;
   logic                      last_shift;

   // Digits are corrected independently; a digit never borrows from its neighbour.
   function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int d = 0; d < DIGITS; d++) begin
         if (v[4*d +: 4] >= 4'd8) r[4*d +: 4] = v[4*d +: 4] - 4'd3;
      end
      return r;
   endfunction

   assign shifted    = {bcd_sr, bin_sr} >> 1;
   assign bcd_next   = fix_digits(shifted[BCD_W+BIN_WIDTH-1:BIN_WIDTH]);
   assign bin_next   = shifted[BIN_WIDTH-1:0];
   assign last_shift = (state == SHIFT) && (cnt == LAST_CNT);

`ifdef BCD_DIGIT_CHECK_EN
   logic bcd_invalid;
   logic error_q;

   always_comb begin
      bcd_invalid = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (i_BCD[4*d +: 4] > 4'd9) bcd_invalid = 1'b1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         error_q <= 1'b0;
      end else if (state == IDLE && i_Start) begin
         error_q <= bcd_invalid;
      end
   end

   assign o_Error = error_q;
`else
   assign o_Error = 1'b0;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      o_Busy     = 1'b0;
      o_Done     = 1'b0;
      case (state)
         IDLE: begin
            if (i_Start) begin
`ifdef BCD_DIGIT_CHECK_EN
               state_next = bcd_invalid ? DONE : SHIFT;
`else
               state_next = SHIFT;
`endif
            end
         end
         SHIFT: begin
            o_Busy = 1'b1;
            if (cnt == LAST_CNT) state_next = DONE;
         end
         DONE: begin
            o_Done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The result register only moves on the final shift, so it holds across idle time.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         bcd_sr   <= '0;
         bin_sr   <= '0;
         cnt      <= '0;
         o_Binary <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_Start) begin
                  bcd_sr <= i_BCD;
                  bin_sr <= '0;
                  cnt    <= '0;
`ifdef BCD_DIGIT_CHECK_EN
                  if (bcd_invalid) o_Binary <= '0;
`endif
               end
            end
            SHIFT: begin
               bcd_sr <= bcd_next;
               bin_sr <= bin_next;
               cnt    <= cnt + 1'b1;
               if (last_shift) o_Binary <= bin_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: default 2-digit instance plus a 3-digit instance.
// Invalid-digit cases are exercised when BCD_DIGIT_CHECK_EN is defined.
module tb_bcd_to_binary_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start;
   logic [7:0]  bcd;
   logic        busy, done, error;
   logic [6:0]  binary;
   logic        start3;
   logic [11:0] bcd3;
   logic        busy3, done3, error3;
   logic [9:0]  binary3;

   int checks = 0;
   int fails  = 0;
   int exp_q[$];
   int err_q[$];
   int exp3_q[$];
   int busy_n;

   bcd_to_binary_seq dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_BCD(bcd),
      .o_Busy(busy), .o_Done(done), .o_Binary(binary), .o_Error(error)
   );

   bcd_to_binary_seq #(.DIGITS(3), .BIN_WIDTH(10)) dut3 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start3), .i_BCD(bcd3),
      .o_Busy(busy3), .o_Done(done3), .o_Binary(binary3), .o_Error(error3)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int bcd_value(input logic [11:0] v, input int digits);
      int r = 0;
      for (int i = digits - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic bit bcd_bad(input logic [11:0] v, input int digits);
      bit b = 1'b0;
      for (int i = 0; i < digits; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
      return b;
   endfunction

   // Call just after a rising edge; the following edge is the accepting edge.
   task automatic applyStimulus(input logic [7:0] v);
      start = 1'b1;
      bcd   = v;
`ifdef BCD_DIGIT_CHECK_EN
      if (bcd_bad({4'h0, v}, 2)) begin
         exp_q.push_back(0);
         err_q.push_back(1);
      end else begin
         exp_q.push_back(bcd_value({4'h0, v}, 2));
         err_q.push_back(0);
      end
`else
      exp_q.push_back(bcd_value({4'h0, v}, 2));
      err_q.push_back(0);
`endif
      @(posedge clk); #1;
      start = 1'b0;
      bcd   = 8'($urandom);
   endtask

   task automatic applyStimulus3(input logic [11:0] v);
      start3 = 1'b1;
      bcd3   = v;
      exp3_q.push_back(bcd_value(v, 3));
      @(posedge clk); #1;
      start3 = 1'b0;
      bcd3   = 12'($urandom);
   endtask

   task automatic waitDone(input bit wide, output int busy_cnt);
      bit seen = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (wide ? done3 : done) begin
            seen = 1'b1;
            break;
         end
         if (wide ? busy3 : busy) busy_cnt++;
      end
      if (!seen) checkOutput("done_timeout", 0, 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) checkOutput("unexpected_done", 1, 0);
         else begin
            checkOutput("binary", int'(binary), exp_q.pop_front());
            checkOutput("error", int'(error), err_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done3) begin
         if (exp3_q.size() == 0) checkOutput("unexpected_done3", 1, 0);
         else begin
            checkOutput("binary3", int'(binary3), exp3_q.pop_front());
            checkOutput("error3", int'(error3), 0);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      start = 1'b0; bcd = '0; start3 = 1'b0; bcd3 = '0;
      #2;
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_binary", int'(binary), 0);
      checkOutput("rst_error", int'(error), 0);
      checkOutput("rst_binary3", int'(binary3), 0);
      #20 rst_n = 1'b1;

      $display("[TB] basic conversion 42");
      @(posedge clk); #1;
      applyStimulus(8'h42);
      waitDone(1'b0, busy_n);
      checkOutput("busy_cycles_42", busy_n, 7);
      @(posedge clk); #1;
      checkOutput("done_pulse_42", int'(done), 0);
      checkOutput("hold_binary_42", int'(binary), 42);

      $display("[TB] back-to-back 99 then 00, start during DONE ignored");
      @(posedge clk); #1;
      applyStimulus(8'h99);
      waitDone(1'b0, busy_n);
      checkOutput("busy_cycles_99", busy_n, 7);
      start = 1'b1;
      bcd   = 8'h77;
      @(posedge clk); #1;
      checkOutput("busy_after_done", int'(busy), 0);
      checkOutput("done_pulse_99", int'(done), 0);
      applyStimulus(8'h00);
      waitDone(1'b0, busy_n);
      checkOutput("busy_cycles_00", busy_n, 7);

      $display("[TB] start during SHIFT ignored");
      @(posedge clk); #1;
      applyStimulus(8'h57);
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1;
      bcd   = 8'h13;
      @(posedge clk); #1;
      start = 1'b0;
      waitDone(1'b0, busy_n);
      checkOutput("busy_after_restart", busy_n, 4);
      repeat (12) @(posedge clk);
      checkOutput("queue_empty_57", exp_q.size(), 0);

      $display("[TB] asynchronous reset mid-conversion");
      #1;
      applyStimulus(8'h88);
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_done", int'(done), 0);
      checkOutput("midrst_binary", int'(binary), 0);
      checkOutput("midrst_error", int'(error), 0);
      void'(exp_q.pop_back());
      void'(err_q.pop_back());
      @(posedge clk); #4;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("no_done_after_rst", int'(binary), 0);
      applyStimulus(8'h21);
      waitDone(1'b0, busy_n);
      checkOutput("busy_cycles_21", busy_n, 7);

      $display("[TB] random valid values");
      repeat (8) begin
         @(posedge clk); #1;
         applyStimulus({4'($urandom_range(9)), 4'($urandom_range(9))});
         waitDone(1'b0, busy_n);
         checkOutput("busy_cycles_rand", busy_n, 7);
      end

      $display("[TB] three-digit instance");
      @(posedge clk); #1;
      applyStimulus3(12'h999);
      waitDone(1'b1, busy_n);
      checkOutput("busy_cycles_999", busy_n, 10);
      @(posedge clk); #1;
      applyStimulus3(12'h512);
      waitDone(1'b1, busy_n);
      checkOutput("busy_cycles_512", busy_n, 10);

`ifdef BCD_DIGIT_CHECK_EN
      $display("[TB] invalid digit detection");
      @(posedge clk); #1;
      applyStimulus(8'h3A);
      @(negedge clk);
      checkOutput("err_done_next", int'(done), 1);
      checkOutput("err_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      checkOutput("err_hold", int'(error), 1);
      checkOutput("err_binary_hold", int'(binary), 0);
      @(posedge clk); #1;
      applyStimulus(8'h10);
      checkOutput("err_cleared", int'(error), 0);
      waitDone(1'b0, busy_n);
      checkOutput("busy_cycles_10", busy_n, 7);
`endif

      repeat (5) @(posedge clk);
      checkOutput("scoreboard_drained", exp_q.size() + exp3_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
